// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: requester ownership tags and FSM states.
package cacheline_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_e;

endpackage

// File: rtl/cacheline_read_tracker.sv
// Outstanding-read table: lowest-free allocation, full flag, address collision
// checks for both requesters, and response match/free.
module cacheline_read_tracker
    import cacheline_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  owner_e            alloc_owner,
    input  logic [ADDR_W-1:0] check_i_addr,
    input  logic [ADDR_W-1:0] check_d_addr,
    output logic              full,
    output logic              collide_i,
    output logic              collide_d,
    input  logic              rsp_valid,
    input  logic [ADDR_W-1:0] rsp_addr,
    output logic              hit,
    output owner_e            hit_owner
);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    owner_e            owner_q [DEPTH];

    logic [DEPTH-1:0]  free_onehot;
    logic [DEPTH-1:0]  match;

    // Lowest clear bit of valid. Built from the current valid vector, so a slot
    // being freed this cycle is never handed out in the same cycle.
    assign free_onehot = ~valid & (valid + DEPTH'(1));
    assign full        = &valid;

    always_comb begin
        collide_i = 1'b0;
        collide_d = 1'b0;
        match     = '0;
        hit_owner = OWNER_I;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && (addr_q[k] == check_i_addr)) collide_i = 1'b1;
            if (valid[k] && (addr_q[k] == check_d_addr)) collide_d = 1'b1;
            match[k] = valid[k] && (addr_q[k] == rsp_addr);
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) hit_owner = owner_q[k];
        end
    end

    assign hit = rsp_valid && (|match);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rsp_valid && match[k]) valid[k] <= 1'b0;
                if (alloc && free_onehot[k]) valid[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (alloc && free_onehot[k]) begin
                addr_q[k]  <= alloc_addr;
                owner_q[k] <= alloc_owner;
            end
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one downstream cacheline port between the
// instruction and data caches, with out-of-order response steering.
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_read,
    input  logic              icache_write,
    input  logic [DATA_W-1:0] icache_wdata,
    output logic              icache_ready,
    output logic [ADDR_W-1:0] icache_raddr,
    output logic [DATA_W-1:0] icache_rdata,
    output logic              icache_rvalid,

    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic              dcache_ready,
    output logic [ADDR_W-1:0] dcache_raddr,
    output logic [DATA_W-1:0] dcache_rdata,
    output logic              dcache_rvalid,

    output logic [ADDR_W-1:0] dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [DATA_W-1:0] dfp_wdata,
    input  logic              dfp_ready,
    input  logic [ADDR_W-1:0] dfp_raddr,
    input  logic [DATA_W-1:0] dfp_rdata,
    input  logic              dfp_rvalid,

    output logic              err
);

    // state  | meaning
    // IDLE   | arbitrate each cycle; acceptance in the same cycle stays here
    // HOLD_I | icache grant locked until dfp_ready
    // HOLD_D | dcache grant locked until dfp_ready (covers multi-beat writes)

    state_e state, state_next;
    owner_e last, last_next;
    logic   grant_i, grant_d;
    logic   i_elig, d_elig;
    logic   full, collide_i, collide_d;
    logic   hit;
    owner_e hit_owner;
    logic   err_q;

    // The icache is read-only; its write channel is deliberately dropped.
    logic unused_icache;
    assign unused_icache = ^{icache_write, icache_wdata};

    cacheline_read_tracker #(
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc        (dfp_read && dfp_ready),
        .alloc_addr   (dfp_addr),
        .alloc_owner  (grant_d ? OWNER_D : OWNER_I),
        .check_i_addr (icache_addr),
        .check_d_addr (dcache_addr),
        .full         (full),
        .collide_i    (collide_i),
        .collide_d    (collide_d),
        .rsp_valid    (dfp_rvalid),
        .rsp_addr     (dfp_raddr),
        .hit          (hit),
        .hit_owner    (hit_owner)
    );

    assign i_elig = icache_read && !full && !collide_i;
    assign d_elig = dcache_write || (dcache_read && !full && !collide_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= OWNER_D;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            last  <= last_next;
            if (dfp_rvalid && !hit) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_elig && d_elig) begin
                    if (last == OWNER_D) grant_i = 1'b1;
                    else                 grant_d = 1'b1;
                end else if (i_elig) begin
                    grant_i = 1'b1;
                end else if (d_elig) begin
                    grant_d = 1'b1;
                end
                if (dfp_ready) begin
                    if (grant_i) last_next = OWNER_I;
                    if (grant_d) last_next = OWNER_D;
                end else if (grant_i) begin
                    state_next = HOLD_I;
                end else if (grant_d) begin
                    state_next = HOLD_D;
                end
            end
            HOLD_I: begin
                grant_i = 1'b1;
                if (dfp_ready) begin
                    state_next = IDLE;
                    last_next  = OWNER_I;
                end
            end
            HOLD_D: begin
                grant_d = 1'b1;
                if (dfp_ready) begin
                    state_next = IDLE;
                    last_next  = OWNER_D;
                end
            end
            default: state_next = IDLE;
        endcase
        // Keep every downstream and handshake output quiet while reset is held.
        if (!rst_n) begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    always_comb begin
        dfp_addr  = '0;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_wdata = '0;
        if (grant_i) begin
            dfp_addr = icache_addr;
            dfp_read = icache_read;
        end else if (grant_d) begin
            dfp_addr  = dcache_addr;
            dfp_read  = dcache_read;
            dfp_write = dcache_write;
            dfp_wdata = dcache_wdata;
        end
    end

    assign icache_ready = grant_i && dfp_ready;
    assign dcache_ready = grant_d && dfp_ready;

    assign icache_rvalid = rst_n && hit && (hit_owner == OWNER_I);
    assign dcache_rvalid = rst_n && hit && (hit_owner == OWNER_D);
    assign icache_raddr  = dfp_raddr;
    assign icache_rdata  = dfp_rdata;
    assign dcache_raddr  = dfp_raddr;
    assign dcache_rdata  = dfp_rdata;

    assign err = err_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed scoreboard bench for cacheline_arbiter: stimulus pushes expected
// acceptances/responses, a negedge monitor pops and compares them.
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  icache_addr, dcache_addr, dfp_addr, dfp_raddr;
    logic [31:0]  icache_raddr, dcache_raddr;
    logic         icache_read, icache_write, dcache_read, dcache_write;
    logic [255:0] icache_wdata, dcache_wdata, dfp_wdata, dfp_rdata;
    logic [255:0] icache_rdata, dcache_rdata;
    logic         icache_ready, dcache_ready, icache_rvalid, dcache_rvalid;
    logic         dfp_read, dfp_write, dfp_ready, dfp_rvalid, err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        bit           owner;
        logic [31:0]  addr;
        bit           write;
        logic [255:0] wdata;
    } acc_t;

    typedef struct {
        bit           owner;
        logic [31:0]  addr;
        logic [255:0] rdata;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    cacheline_arbiter #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icache_addr   (icache_addr),
        .icache_read   (icache_read),
        .icache_write  (icache_write),
        .icache_wdata  (icache_wdata),
        .icache_ready  (icache_ready),
        .icache_raddr  (icache_raddr),
        .icache_rdata  (icache_rdata),
        .icache_rvalid (icache_rvalid),
        .dcache_addr   (dcache_addr),
        .dcache_read   (dcache_read),
        .dcache_write  (dcache_write),
        .dcache_wdata  (dcache_wdata),
        .dcache_ready  (dcache_ready),
        .dcache_raddr  (dcache_raddr),
        .dcache_rdata  (dcache_rdata),
        .dcache_rvalid (dcache_rvalid),
        .dfp_addr      (dfp_addr),
        .dfp_read      (dfp_read),
        .dfp_write     (dfp_write),
        .dfp_wdata     (dfp_wdata),
        .dfp_ready     (dfp_ready),
        .dfp_raddr     (dfp_raddr),
        .dfp_rdata     (dfp_rdata),
        .dfp_rvalid    (dfp_rvalid),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [255:0] wd(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_5A5A}};
    endfunction

    function automatic logic [255:0] rd(input logic [31:0] a);
        return {8{a}};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input bit o, input logic [31:0] a, input bit w);
        acc_t e;
        e.owner = o; e.addr = a; e.write = w; e.wdata = wd(a);
        exp_acc.push_back(e);
    endtask

    task automatic exp_r(input bit o, input logic [31:0] a);
        rsp_t e;
        e.owner = o; e.addr = a; e.rdata = rd(a);
        exp_rsp.push_back(e);
    endtask

    task automatic rsp_on(input logic [31:0] a);
        dfp_rvalid = 1'b1;
        dfp_raddr  = a;
        dfp_rdata  = rd(a);
    endtask

    task automatic rsp_off();
        dfp_rvalid = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] a);
        rsp_on(a);
        step();
        rsp_off();
    endtask

    // Raise a request, wait (bounded) for its ready, then drop it after the edge.
    task automatic req(input bit d, input logic [31:0] a, input bit w, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        if (d) begin
            dcache_addr = a; dcache_read = !w; dcache_write = w; dcache_wdata = wd(a);
        end else begin
            icache_addr = a; icache_read = 1'b1;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (d ? dcache_ready : icache_ready) begin
                got = 1'b1;
                acc_cyc = cycle;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr %0h never accepted within 40 cycles", a);
        end
        step();
        if (d) begin
            dcache_read = 1'b0; dcache_write = 1'b0;
        end else begin
            icache_read = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((dfp_read || dfp_write) && dfp_ready) begin
                chk("acc_one_ready", 64'(icache_ready ^ dcache_ready), 64'd1);
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acc_unexpected: got addr %0h required no acceptance", dfp_addr);
                end else begin
                    acc_t e;
                    e = exp_acc.pop_front();
                    chk("acc_owner", 64'(dcache_ready), 64'(e.owner));
                    chk("acc_addr", 64'(dfp_addr), 64'(e.addr));
                    chk("acc_write", 64'(dfp_write), 64'(e.write));
                    chk("acc_read", 64'(dfp_read), 64'(!e.write));
                    if (e.write) chk("acc_wdata_ok", 64'(dfp_wdata == e.wdata), 64'd1);
                end
            end
            if (icache_rvalid || dcache_rvalid) begin
                chk("rsp_one_rvalid", 64'(icache_rvalid ^ dcache_rvalid), 64'd1);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got raddr %0h required no response", icache_raddr);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_owner", 64'(dcache_rvalid), 64'(e.owner));
                    chk("rsp_raddr_i", 64'(icache_raddr), 64'(e.addr));
                    chk("rsp_raddr_d", 64'(dcache_raddr), 64'(e.addr));
                    chk("rsp_rdata_ok", 64'((icache_rdata == e.rdata) && (dcache_rdata == e.rdata)), 64'd1);
                end
            end
        end
    end

    initial begin
        int ci, cd, cw;
        rst_n = 1'b0;
        icache_addr = 32'h1; icache_read = 1'b1; icache_write = 1'b0; icache_wdata = '0;
        dcache_addr = 32'h2; dcache_read = 1'b1; dcache_write = 1'b0; dcache_wdata = '0;
        dfp_ready = 1'b1; dfp_raddr = '0; dfp_rdata = '0; dfp_rvalid = 1'b0;

        // Reset with requests present: nothing may leak out.
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", 64'({dfp_read, dfp_write, icache_ready, dcache_ready, icache_rvalid, dcache_rvalid}), 64'd0);
        end
        step();
        icache_read = 1'b0; dcache_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_outs", 64'({dfp_read, dfp_write, icache_ready, dcache_ready, icache_rvalid, dcache_rvalid}), 64'd0);
        chk("post_rst_err", 64'(err), 64'd0);
        step();

        // Simultaneous reads: icache wins the first tie, responses out of order.
        exp_a(0, 32'h1000, 0);
        exp_a(1, 32'h2000, 0);
        fork
            req(0, 32'h1000, 0, ci);
            req(1, 32'h2000, 0, cd);
        join
        chk("tie_d_after_i", 64'(cd - ci), 64'd1);
        exp_r(1, 32'h2000);
        rsp(32'h2000);
        exp_r(0, 32'h1000);
        rsp(32'h1000);

        // Locked multi-beat write with an icache read raised mid-write.
        dfp_ready = 1'b0;
        exp_a(1, 32'h3000, 1);
        exp_a(0, 32'h5000, 0);
        dcache_addr = 32'h3000; dcache_write = 1'b1; dcache_wdata = wd(32'h3000);
        @(negedge clk);
        chk("wr_hold_write", 64'(dfp_write), 64'd1);
        chk("wr_hold_dready", 64'(dcache_ready), 64'd0);
        step();
        icache_addr = 32'h5000; icache_read = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("wr_hold_iready", 64'(icache_ready), 64'd0);
            chk("wr_hold_addr", 64'(dfp_addr), 64'h3000);
            chk("wr_hold_noread", 64'(dfp_read), 64'd0);
            step();
        end
        dfp_ready = 1'b1;
        @(negedge clk);
        chk("wr_done_dready", 64'(dcache_ready), 64'd1);
        chk("wr_done_iready", 64'(icache_ready), 64'd0);
        step();
        dcache_write = 1'b0;
        @(negedge clk);
        chk("after_wr_iready", 64'(icache_ready), 64'd1);
        step();
        icache_read = 1'b0;
        exp_r(0, 32'h5000);
        rsp(32'h5000);

        // Collision: icache read to an address dcache has outstanding.
        exp_a(1, 32'h4000, 0);
        req(1, 32'h4000, 0, cd);
        exp_a(0, 32'h4000, 0);
        icache_addr = 32'h4000; icache_read = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("coll_stall", 64'(icache_ready), 64'd0);
            step();
        end
        exp_r(1, 32'h4000);
        rsp_on(32'h4000);
        @(negedge clk);
        chk("coll_stall_rsp", 64'(icache_ready), 64'd0);
        step();
        rsp_off();
        @(negedge clk);
        chk("coll_release", 64'(icache_ready), 64'd1);
        step();
        icache_read = 1'b0;
        exp_r(0, 32'h4000);
        rsp(32'h4000);

        // Second tie after an icache grant: dcache goes first.
        exp_a(1, 32'hB000, 0);
        exp_a(0, 32'hA000, 0);
        fork
            req(0, 32'hA000, 0, ci);
            req(1, 32'hB000, 0, cd);
        join
        chk("tie2_i_after_d", 64'(ci - cd), 64'd1);
        exp_r(0, 32'hA000);
        rsp(32'hA000);
        exp_r(1, 32'hB000);
        rsp(32'hB000);

        // Fill the table; fifth read stalls, a write still passes.
        exp_a(0, 32'h100, 0); req(0, 32'h100, 0, ci);
        exp_a(1, 32'h200, 0); req(1, 32'h200, 0, cd);
        exp_a(0, 32'h300, 0); req(0, 32'h300, 0, ci);
        exp_a(1, 32'h400, 0); req(1, 32'h400, 0, cd);
        exp_a(1, 32'h600, 1);
        exp_a(0, 32'h500, 0);
        icache_addr = 32'h500; icache_read = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_stall", 64'(icache_ready), 64'd0);
            step();
        end
        req(1, 32'h600, 1, cw);
        exp_r(1, 32'h200);
        rsp_on(32'h200);
        @(negedge clk);
        chk("full_stall_rsp", 64'(icache_ready), 64'd0);
        step();
        rsp_off();
        @(negedge clk);
        chk("full_release", 64'(icache_ready), 64'd1);
        step();
        icache_read = 1'b0;
        exp_r(0, 32'h100); rsp(32'h100);
        exp_r(0, 32'h300); rsp(32'h300);
        exp_r(1, 32'h400); rsp(32'h400);
        exp_r(0, 32'h500); rsp(32'h500);

        // Unmatched response sets sticky err.
        chk("err_before", 64'(err), 64'd0);
        rsp_on(32'hDEAD_0000);
        @(negedge clk);
        chk("orphan_rvalid", 64'({icache_rvalid, dcache_rvalid}), 64'd0);
        step();
        rsp_off();
        @(negedge clk);
        chk("orphan_err", 64'(err), 64'd1);
        repeat (3) step();
        @(negedge clk);
        chk("orphan_err_held", 64'(err), 64'd1);
        step();

        // Reset during HOLD_D with two reads outstanding.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_err", 64'(err), 64'd0);
        step();
        exp_a(0, 32'h700, 0); req(0, 32'h700, 0, ci);
        exp_a(1, 32'h800, 0); req(1, 32'h800, 0, cd);
        dfp_ready = 1'b0;
        dcache_addr = 32'h900; dcache_write = 1'b1; dcache_wdata = wd(32'h900);
        repeat (2) begin
            @(negedge clk);
            chk("hold_d_write", 64'(dfp_write), 64'd1);
            step();
        end
        rst_n = 1'b0;
        dcache_write = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", 64'({dfp_read, dfp_write, icache_ready, dcache_ready, icache_rvalid, dcache_rvalid}), 64'd0);
        step();
        rst_n = 1'b1;
        dfp_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_after", 64'({dfp_read, dfp_write, icache_ready, dcache_ready, err}), 64'd0);
        step();
        rsp_on(32'h700);
        @(negedge clk);
        chk("stale_rvalid", 64'({icache_rvalid, dcache_rvalid}), 64'd0);
        step();
        rsp_off();
        @(negedge clk);
        chk("stale_err", 64'(err), 64'd1);
        step();

        chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
